// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and restoring divide with flush cancel,
// EX stall request and HI/LO hold until the pipeline advances.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit MUL_ITER = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             advance,
    output logic             stallreq,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
    logic               accept, a_neg, b_neg, ge;
    logic [WIDTH-1:0]   mag_a, mag_b, mquo, dquo, drem, qres, rres;
    logic [WIDTH:0]     msum, shl, diff;
    logic [2*WIDTH-1:0] full, prod, sprod;

    assign accept = (state_q == IDLE) & start & ~flush;
    assign a_neg  = ~op[0] & src_a[WIDTH-1];
    assign b_neg  = ~op[0] & src_b[WIDTH-1];
    assign mag_a  = a_neg ? -src_a : src_a;
    assign mag_b  = b_neg ? -src_b : src_b;
    // Shift-add step: {rem, quo} is the running product, quo holds the unconsumed multiplier bits.
    assign msum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    assign mquo   = {msum[0], quo_q[WIDTH-1:1]};
    // Restoring step: the borrow out of diff decides the quotient bit.
    assign shl    = {rem_q, quo_q[WIDTH-1]};
    assign diff   = shl - {1'b0, dvs_q};
    assign ge     = ~diff[WIDTH];
    assign drem   = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    assign dquo   = {quo_q[WIDTH-2:0], ge};
    assign full   = {{WIDTH{1'b0}}, quo_q} * {{WIDTH{1'b0}}, dvs_q};
    assign prod   = MUL_ITER ? {msum[WIDTH:1], mquo} : full;
    assign sprod  = neg_q ? -prod : prod;
    assign qres   = neg_q ? -dquo : dquo;
    assign rres   = rneg_q ? -drem : drem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (accept) begin
                div_d  = op[1];
                neg_d  = a_neg ^ b_neg;
                rneg_d = a_neg;
                quo_d  = mag_a;
                dvs_d  = mag_b;
                rem_d  = '0;
                cnt_d  = (!op[1] && !MUL_ITER) ? CW'(1) : CW'(WIDTH);
                if (op[1] && src_b == '0) begin
                    state_d = DONE;
                    hi_d    = src_a;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
        end else if (state_q == RUN) begin
            if (flush) begin
                state_d = IDLE;
            end else begin
                rem_d = div_q ? drem : msum[WIDTH:1];
                quo_d = div_q ? dquo : mquo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    dbz_d   = 1'b0;
                    hi_d    = div_q ? rres : sprod[2*WIDTH-1:WIDTH];
                    lo_d    = div_q ? qres : sprod[WIDTH-1:0];
                end
            end
        end else if (advance | flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = state_q == RUN;
    assign done        = state_q == DONE;
    assign stallreq    = accept | busy;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of the 32-bit iterative and single-cycle-multiply units
// and an 8-bit unit.
module tb_muldiv_unit;
    logic        clk, rst, fl, st, adv, fl8, st8, adv8;
    logic [1:0]  opc, op8;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic        sr1, bz1, dn1, dz1, sr0, bz0, dn0, dz0, sr8, bz8, dn8, dz8;
    logic [31:0] hi1, lo1, hi0, lo0;
    logic [7:0]  hi8, lo8;
    int          checks = 0, errors = 0, n, d;

    muldiv_unit #(.WIDTH(32), .MUL_ITER(1'b1)) u1 (
        .clk(clk), .rst(rst), .flush(fl), .start(st), .op(opc), .src_a(a), .src_b(b),
        .advance(adv), .stallreq(sr1), .busy(bz1), .done(dn1), .div_by_zero(dz1), .hi(hi1), .lo(lo1));
    muldiv_unit #(.WIDTH(32), .MUL_ITER(1'b0)) u0 (
        .clk(clk), .rst(rst), .flush(fl), .start(st), .op(opc), .src_a(a), .src_b(b),
        .advance(adv), .stallreq(sr0), .busy(bz0), .done(dn0), .div_by_zero(dz0), .hi(hi0), .lo(lo0));
    muldiv_unit #(.WIDTH(8), .MUL_ITER(1'b1)) u8 (
        .clk(clk), .rst(rst), .flush(fl8), .start(st8), .op(op8), .src_a(a8), .src_b(b8),
        .advance(adv8), .stallreq(sr8), .busy(bz8), .done(dn8), .div_by_zero(dz8), .hi(hi8), .lo(lo8));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic release32;
        st = 0; adv = 1;
        step;
        adv = 0;
    endtask

    initial begin
        clk = 0; rst = 1; fl = 0; st = 0; adv = 0; opc = 0; a = 0; b = 0;
        fl8 = 0; st8 = 0; adv8 = 0; op8 = 0; a8 = 0; b8 = 0;
        step; step;
        chk("rst busy", bz1, 0); chk("rst done", dn1, 0); chk("rst stallreq", sr1, 0);
        chk("rst hi", hi1, 0); chk("rst lo", lo1, 0); chk("rst dbz", dz1, 0);
        rst = 0;
        step;
        // divu 100/7, sources scrambled after acceptance
        st = 1; opc = 2'b11; a = 100; b = 7;
        #1;
        n = 0; d = 0;
        for (int i = 0; i < 33; i++) begin
            if (sr1) n++;
            if (dn1) d++;
            step;
            a = 32'hDEAD_BEEF; b = 1;
        end
        chk("divu stall cycles", n, 33); chk("divu early done", d, 0);
        chk("divu done", dn1, 1); chk("divu stallreq in DONE", sr1, 0);
        chk("divu lo", lo1, 14); chk("divu hi", hi1, 2); chk("divu dbz", dz1, 0);
        chk("divu lo mi0", lo0, 14);
        // hold in DONE with start still high
        for (int i = 0; i < 3; i++) begin
            step;
            chk("hold done", dn1, 1); chk("hold busy", bz1, 0); chk("hold lo", lo1, 14);
        end
        release32;
        chk("advance idle done", dn1, 0); chk("advance idle busy", bz1, 0);
        // signed divide -7 / 2
        st = 1; opc = 2'b10; a = 32'hFFFF_FFF9; b = 2;
        repeat (33) step;
        chk("div s done", dn1, 1); chk("div s lo", lo1, 32'hFFFF_FFFD); chk("div s hi", hi1, 32'hFFFF_FFFF);
        release32;
        // divide by zero
        st = 1; opc = 2'b11; a = 5; b = 0;
        step;
        chk("dbz done T1", dn1, 1); chk("dbz lo", lo1, 32'hFFFF_FFFF); chk("dbz hi", hi1, 5);
        chk("dbz flag", dz1, 1); chk("dbz stallreq", sr1, 0);
        release32;
        // signed multiply -1 * 2
        st = 1; opc = 2'b00; a = 32'hFFFF_FFFF; b = 2;
        step;
        chk("mul0 busy T1", bz0, 1);
        step;
        chk("mul0 s done T2", dn0, 1); chk("mul0 s hi", hi0, 32'hFFFF_FFFF); chk("mul0 s lo", lo0, 32'hFFFF_FFFE);
        chk("mul1 not done T2", dn1, 0);
        repeat (31) step;
        chk("mul1 s done", dn1, 1); chk("mul1 s hi", hi1, 32'hFFFF_FFFF); chk("mul1 s lo", lo1, 32'hFFFF_FFFE);
        chk("mul1 s dbz", dz1, 0); chk("mul0 still done", dn0, 1);
        release32;
        // unsigned multiply 0xFFFFFFFF * 2
        st = 1; opc = 2'b01;
        repeat (2) step;
        chk("mul0 u done T2", dn0, 1); chk("mul0 u hi", hi0, 1); chk("mul0 u lo", lo0, 32'hFFFF_FFFE);
        repeat (31) step;
        chk("mul1 u done", dn1, 1); chk("mul1 u hi", hi1, 1); chk("mul1 u lo", lo1, 32'hFFFF_FFFE);
        release32;
        // flush at T10 of a divide
        st = 1; opc = 2'b11; a = 100; b = 7;
        repeat (10) step;
        chk("flush pre busy", bz1, 1);
        fl = 1; st = 0;
        step;
        chk("flush busy", bz1, 0); chk("flush stallreq", sr1, 0); chk("flush done", dn1, 0);
        chk("flush hi", hi1, 1); chk("flush lo", lo1, 32'hFFFF_FFFE);
        fl = 0; d = 0;
        for (int i = 0; i < 30; i++) begin
            step;
            if (dn1 || bz1) d++;
        end
        chk("flush no activity", d, 0);
        // flush together with start in IDLE
        st = 1; fl = 1;
        #1;
        chk("flush+start stallreq", sr1, 0);
        step;
        chk("flush+start busy", bz1, 0); chk("flush+start done", dn1, 0);
        st = 0; fl = 0;
        // 8-bit: most-negative / -1
        st8 = 1; op8 = 2'b10; a8 = 8'h80; b8 = 8'hFF;
        repeat (8) step;
        chk("w8 not done T8", dn8, 0);
        step;
        chk("w8 done T9", dn8, 1); chk("w8 lo", lo8, 8'h80); chk("w8 hi", hi8, 8'h00);
        st8 = 0; adv8 = 1;
        step;
        adv8 = 0;
        // 8-bit divu 100/7, then reset mid-RUN
        st8 = 1; op8 = 2'b11; a8 = 100; b8 = 7;
        repeat (9) step;
        chk("w8 divu lo", lo8, 14); chk("w8 divu hi", hi8, 2);
        st8 = 0; adv8 = 1;
        step;
        adv8 = 0; st8 = 1; a8 = 8'hF0; b8 = 3;
        repeat (4) step;
        chk("w8 busy mid", bz8, 1);
        rst = 1; st8 = 0;
        step;
        chk("rst mid busy", bz8, 0); chk("rst mid done", dn8, 0); chk("rst mid stallreq", sr8, 0);
        chk("rst mid lo", lo8, 0); chk("rst mid hi", hi8, 0); chk("rst mid dbz", dz8, 0);
        rst = 0;
        step;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
